// File: rtl/pc_sequencer_pkg.sv
// Encodings and state constants shared between the PC sequencer and the control unit.
package pc_sequencer_pkg;

  localparam logic [1:0] PC_HOLD  = 2'd0;
  localparam logic [1:0] PC_INC   = 2'd1;
  localparam logic [1:0] PC_JUMP  = 2'd2;
  localparam logic [1:0] PC_DELAY = 2'd3;

  localparam logic [1:0] BQ_NONE = 2'd0;
  localparam logic [1:0] BQ_EQ   = 2'd1;
  localparam logic [1:0] BQ_NE   = 2'd2;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DELAY = 1'b1;

  // Branch decision given the branch mode and the operand equality result.
  function automatic logic branch_taken(input logic [1:0] bq, input logic equal);
    return ((bq == BQ_EQ) && equal) || ((bq == BQ_NE) && !equal);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-unit <-> PC-sequencer bus: PC control flags, operands and sequencer outputs.
interface pc_sequencer_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int DLY_W  = 16
);
  logic              interruption;
  logic [1:0]        flagPC;
  logic              flagJR;
  logic [1:0]        flagBQ;
  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opB;
  logic [ADDR_W-1:0] target;
  logic [DLY_W-1:0]  dly_units;
  logic              flagJB;
  logic [ADDR_W-1:0] pc;
  logic              delay_busy;

  modport master (
    output interruption, flagPC, flagJR, flagBQ, opA, opB, target, dly_units,
    input  flagJB, pc, delay_busy
  );

  modport slave (
    input  interruption, flagPC, flagJR, flagBQ, opA, opB, target, dly_units,
    output flagJB, pc, delay_busy
  );
endinterface

// File: rtl/pc_sequencer_delay_timer.sv
// Prescaler plus unit counter; done pulses on the final edge of an N-unit delay.
module delay_timer
  import pc_sequencer_pkg::*;
#(
  parameter int DLY_W        = 16,
  parameter int CLK_PER_UNIT = 50000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [DLY_W-1:0] units,
  input  logic             freeze,
  output logic             done
);

  localparam int PRE_W = (CLK_PER_UNIT > 1) ? $clog2(CLK_PER_UNIT) : 1;
  localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(CLK_PER_UNIT - 1);

  logic [PRE_W-1:0] pre_reg;
  logic [DLY_W-1:0] unit_reg;

  // The counter idles at zero, so done can only fire inside a started delay.
  assign done = !freeze && (unit_reg == DLY_W'(1)) && (pre_reg == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_reg  <= '0;
      unit_reg <= '0;
    end else if (start) begin
      pre_reg  <= PRE_RELOAD;
      unit_reg <= units;
    end else if (!freeze && (unit_reg != '0)) begin
      if (pre_reg != '0) begin
        pre_reg <= pre_reg - PRE_W'(1);
      end else begin
        unit_reg <= unit_reg - DLY_W'(1);
        if (unit_reg != DLY_W'(1)) begin
          pre_reg <= PRE_RELOAD;
        end
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: hold/increment/jump/timed-delay FSM plus branch comparator.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int DLY_W        = 16,
  parameter int CLK_PER_UNIT = 50000
) (
  input  logic             clock,
  input  logic             reset,
  pc_sequencer_if.slave    bus
);

  logic [0:0]        state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              timer_start;
  logic              timer_done;

  assign bus.flagJB     = branch_taken(bus.flagBQ, bus.opA == bus.opB);
  assign bus.pc         = pc_reg;
  assign bus.delay_busy = (state_reg == ST_DELAY);

  // A zero-length delay degenerates to an increment and never starts the timer.
  assign timer_start = (state_reg == ST_RUN) && !bus.interruption &&
                       (bus.flagPC == PC_DELAY) && (bus.dly_units != '0);

  delay_timer #(
    .DLY_W       (DLY_W),
    .CLK_PER_UNIT(CLK_PER_UNIT)
  ) u_delay_timer (
    .clock (clock),
    .reset (reset),
    .start (timer_start),
    .units (bus.dly_units),
    .freeze(bus.interruption),
    .done  (timer_done)
  );

  always_comb begin
    pc_next    = pc_reg;
    state_next = state_reg;
    if (!bus.interruption) begin
      case (state_reg)
        ST_RUN: begin
          case (bus.flagPC)
            PC_INC:  pc_next = pc_reg + ADDR_W'(1);
            PC_JUMP: pc_next = bus.flagJR ? bus.opA[ADDR_W-1:0] : bus.target;
            PC_DELAY: begin
              if (bus.dly_units == '0) pc_next = pc_reg + ADDR_W'(1);
              else                     state_next = ST_DELAY;
            end
            default: pc_next = pc_reg;
          endcase
        end
        default: begin
          // Flags are ignored here: the DLY instruction stays on the bus while pc holds.
          if (timer_done) begin
            pc_next    = pc_reg + ADDR_W'(1);
            state_next = ST_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_RUN;
      pc_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer that executes the PC-control flags produced by the control unit. It holds, increments, jumps, jumps-to-register, or runs a timed delay, and drives the instruction-memory address. It also computes the branch-taken flag `flagJB` that the control unit consumes for BEQ/BNQ. It sits between the control unit, the register file read ports and the instruction memory.

## Interface
Parameters:
- `ADDR_W`, 10: instruction address width.
- `DATA_W`, 32: register data width.
- `DLY_W`, 16: width of the delay unit count.
- `CLK_PER_UNIT`, 50000: clocks per delay unit (1 ms at 50 MHz). Must be ≥1.

Ports:
- `clock`, in, 1: rising-edge clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `interruption`, in, 1: freeze request.
- `flagPC`, in, 2: 0 = hold, 1 = increment, 2 = jump, 3 = delay.
- `flagJR`, in, 1: jump source is register, not immediate.
- `flagBQ`, in, 2: 0 = none, 1 = branch-if-equal, 2 = branch-if-not-equal, 3 = none.
- `opA`, in, DATA_W: register operand A.
- `opB`, in, DATA_W: register operand B.
- `target`, in, ADDR_W: immediate jump/branch target.
- `dly_units`, in, DLY_W: delay length in units.
- `flagJB`, out, 1: branch taken (combinational).
- `pc`, out, ADDR_W: current instruction address (registered).
- `delay_busy`, out, 1: high while in DELAY.

## Operation
- `flagJB` = (`flagBQ`==1 && `opA`==`opB`) || (`flagBQ`==2 && `opA`!=`opB`). Purely combinational and independent of state and `interruption`.
- FSM has two states: RUN and DELAY. Reset sets state RUN, `pc`=0, unit counter 0, prescaler 0, `delay_busy`=0.
- `interruption`=1 takes priority over all flags in both states. `pc`, state and both counters hold.
- RUN, with `interruption`=0:
  - `flagPC`=0: hold. This also covers HLT and unknown opcodes.
  - `flagPC`=1: `pc` ← `pc`+1, modulo 2^ADDR_W (0x3FF wraps to 0x000).
  - `flagPC`=2: `pc` ← `opA`[ADDR_W-1:0] if `flagJR`=1, else `pc` ← `target`. Upper bits of `opA` are ignored.
  - `flagPC`=3 with `dly_units`=0: behaves as increment.
  - `flagPC`=3 with `dly_units`=N>0: go to DELAY. Load unit counter ← N and prescaler ← CLK_PER_UNIT-1. `pc` holds.
- DELAY, with `interruption`=0. The flag inputs are ignored because the DLY instruction stays on the bus while `pc` is held.
  - Each edge: if prescaler≠0, prescaler decrements.
  - Otherwise, if unit counter==1: `pc` ← `pc`+1 and state ← RUN.
  - Otherwise: unit counter decrements and prescaler ← CLK_PER_UNIT-1.
- Reset during DELAY aborts the delay: state RUN, `pc`=0.

## Timing
- `pc` updates on the rising edge after the flags are presented, so latency is one clock. `flagJB` has zero latency.
- Delay of N>0: the entering edge is E0. `pc` increments at edge E0 + N·CLK_PER_UNIT.
- `delay_busy` is high for exactly N·CLK_PER_UNIT cycles, starting the cycle after E0. It falls together with the `pc` increment.
- An interrupted edge stretches the delay by exactly one cycle per cycle of `interruption`.
- Registered outputs: `pc` and `delay_busy`. There is no combinational path from the flags to `pc`.

## Structure
- Shared package holds the `flagPC` encodings (PC_HOLD, PC_INC, PC_JUMP, PC_DELAY), the `flagBQ` encodings (BQ_NONE, BQ_EQ, BQ_NE) and the state enum (ST_RUN, ST_DELAY). These are shared with the control unit.
- One sub-module, `delay_timer`, contains the prescaler plus unit counter. It has `start`, `units`, `freeze` and `done` ports. `pc_sequencer` holds the FSM, PC register and branch comparator.

## Test plan
- Reset then `flagPC`=1 for 3 cycles → `pc` = 0, 1, 2, 3. Reset asserted at `pc`=5 → `pc`=0 next edge.
- `pc`=0x3FF, `flagPC`=1 → `pc`=0x000. `flagPC`=0 for 4 cycles → `pc` constant.
- `flagPC`=2, `flagJR`=0, `target`=0x120 → `pc`=0x120. `flagJR`=1, `opA`=0xFFFF_F055 → `pc`=0x055.
- Branch flag cases:
  - `flagBQ`=1, `opA`=`opB`=7 → `flagJB`=1.
  - `flagBQ`=1, `opB`=8 → 0.
  - `flagBQ`=2, `opB`=8 → 1.
  - `flagBQ`=0 → 0.
- CLK_PER_UNIT=4, `dly_units`=3, `flagPC`=3 held → `delay_busy` high for 12 cycles, then `pc` increments once only. `dly_units`=0 → immediate increment, `delay_busy` never rises.
- Same delay with `interruption` pulsed for 2 cycles mid-delay → `pc` increments at edge E0+14. `interruption`=1 in RUN with `flagPC`=1 → `pc` holds.
